iq_demod_integrator: RTL
========================

# iq_demod_integrator

Downstream consumer of the CORDIC I/Q oscillator. Mixes each signed ADC sample with the oscillator's cosine/sine pair (full-precision signed multiply) and integrates the products over a programmable window of N accepted samples. At the end of each window it emits one I/Q accumulator pair with a single-cycle valid strobe. It is the lock-in/demodulation stage between the oscillator/ADC front end and the readout logic.

## Interface
- INT_DATA_WIDTH, 20, oscillator data width; LO inputs are INT_DATA_WIDTH+1 bits signed, matching the oscillator outputs
- INT_ADC_WIDTH, 14, signed ADC sample width
- INT_INTEG_CNT_WIDTH, 16, width of window-length input and sample counter
- Derived: PW = INT_ADC_WIDTH+INT_DATA_WIDTH+1 (product width); ACC_W = PW+INT_INTEG_CNT_WIDTH (accumulator/output width)

- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- i_lo_valid  in  1  oscillator sample valid; i_lo_cos, i_lo_sin and i_adc are sampled only when high
- i_lo_cos  in  INT_DATA_WIDTH+1  signed LO cosine
- i_lo_sin  in  INT_DATA_WIDTH+1  signed LO sine
- i_adc  in  INT_ADC_WIDTH  signed ADC sample, time-aligned with i_lo_valid
- i_enable  in  1  run enable; low aborts and holds the block idle
- i_integ_len  in  INT_INTEG_CNT_WIDTH  window length in samples; 0 is treated as 1
- o_valid  out  1  one-cycle strobe: o_i/o_q hold a completed window
- o_i  out  ACC_W  signed sum of adc*cos over the window
- o_q  out  ACC_W  signed sum of adc*sin over the window
- o_busy  out  1  high while a window is partially accumulated

## Operation
- State machine: IDLE (i_enable=0) and RUN (i_enable=1). IDLE->RUN when i_enable=1 at a clock edge. RUN->IDLE when i_enable=0.
- Accepted sample: a cycle with i_lo_valid=1 and i_enable=1. Only accepted samples enter the pipeline.
- Pipeline:
  - S1 registers adc, cos and sin plus a valid bit.
  - S2 registers the two full-precision signed products (PW bits each) plus a valid bit.
  - S3 is the accumulator stage.
- S3 behaviour:
  - On each valid product, acc_i/acc_q += sign-extended product and cnt += 1.
  - When cnt == len_eff-1 (last sample), o_i/o_q <= acc + product, o_valid <= 1, and acc <= 0, cnt <= 0 in the same edge. The next product starts a new window with no gap.
- len_eff = max(i_integ_len,1). It is reloaded every cycle while cnt==0 and frozen while cnt>0. Changes to i_integ_len mid-window take effect at the next window.
- Abort: i_enable=0 in any cycle clears the S1/S2 valid bits, acc_i, acc_q and cnt at that edge. The partial window is discarded and no o_valid is produced for it. o_i/o_q keep their last completed values.
- Arithmetic:
  - Signed two's complement throughout; no rounding, truncation or saturation.
  - ACC_W guarantees no overflow for up to 2^INT_INTEG_CNT_WIDTH-1 full-scale samples.
- o_busy = (cnt != 0).

## Timing
- Reset (async assert, sync-safe release):
  - o_valid=0, o_i=0, o_q=0, o_busy=0.
  - cnt=0, acc=0, pipeline valids=0.
  - State is IDLE.
- Latency: an accepted sample in cycle t that completes a window appears as o_valid=1 in cycle t+3.
- Throughput: one sample per clock, with sustained back-to-back windows. With len_eff=1, o_valid may be high every cycle.
- o_valid is high for exactly one cycle per completed window. o_i/o_q are stable until the next o_valid.
- Gaps in i_lo_valid stall accumulation only; cnt and acc hold.
- Simultaneous abort and last product: abort wins, and no o_valid is produced.

## Test plan
- Reset: assert rst_n=0 mid-run with random inputs -> all outputs 0 immediately (asynchronous); after release with i_enable=0, o_valid stays 0 for 100 cycles.
- Constant mix: cos=1048575, sin=0, adc=100, len=4, continuous valid -> o_valid every 4 cycles, first at 3 cycles after the 4th sample; o_i=419430000, o_q=0.
- Per-sample: len=0, adc=-3, cos=5, sin=-7 each cycle -> o_valid every cycle after 3-cycle latency; o_i=-15, o_q=21.
- Abort: len=4, drop i_enable after 2 accepted samples, re-enable, send 4 samples adc=1, cos=sin=1 -> no o_valid for the aborted window; next window o_i=o_q=4.
- Gapped valid + length change: i_lo_valid every other cycle, len=3, i_integ_len changed to 5 during window -> first output after 3 accepted samples, next window uses 5.
- Extremes: adc=-8192, cos=sin=-1048576, len=65535 -> o_i=o_q=562941363486720 (65535*2^33), no overflow; random stimulus matches a 64-bit golden model.

Source files
------------

// File: rtl/iq_demod_integrator.sv
// I/Q demodulating integrator: mixes each signed ADC sample with the LO
// cosine/sine pair and sums the products over a programmable window,
// emitting one I/Q pair per completed window with a one-cycle strobe.
module iq_demod_integrator #(
  parameter int INT_DATA_WIDTH      = 20,
  parameter int INT_ADC_WIDTH       = 14,
  parameter int INT_INTEG_CNT_WIDTH = 16,
  localparam int PW    = INT_ADC_WIDTH + INT_DATA_WIDTH + 1,
  localparam int ACC_W = PW + INT_INTEG_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_lo_valid,
  input  logic signed [INT_DATA_WIDTH:0]   i_lo_cos,
  input  logic signed [INT_DATA_WIDTH:0]   i_lo_sin,
  input  logic signed [INT_ADC_WIDTH-1:0]  i_adc,
  input  logic                             i_enable,
  input  logic [INT_INTEG_CNT_WIDTH-1:0]   i_integ_len,
  output logic                             o_valid,
  output logic signed [ACC_W-1:0]          o_i,
  output logic signed [ACC_W-1:0]          o_q,
  output logic                             o_busy
);

  localparam int CW = INT_INTEG_CNT_WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, next_state;
  logic   active;

  logic                            s1_valid;
  logic signed [INT_ADC_WIDTH-1:0] s1_adc;
  logic signed [INT_DATA_WIDTH:0]  s1_cos, s1_sin;

  logic                            s2_valid;
  logic signed [PW-1:0]            s2_pi, s2_pq;

  logic signed [ACC_W-1:0]         acc_i, acc_q;
  logic signed [ACC_W-1:0]         sum_i, sum_q;
  logic [CW-1:0]                   cnt;
  logic [CW-1:0]                   len_q, len_use;
  logic                            last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state; the pipeline runs in any cycle where enable is high,
  // so a sample arriving in the same cycle enable rises is accepted
  always_comb begin
    next_state = state;
    active     = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable) begin
          next_state = RUN;
          active     = 1'b1;
        end
      end
      RUN: begin
        if (!i_enable) next_state = IDLE;
        else           active     = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Window length: live from the input between windows, frozen inside one
  always_comb begin
    len_use = len_q;
    if (cnt == '0) len_use = (i_integ_len == '0) ? CW'(1) : i_integ_len;
  end

  assign last  = (cnt == len_use - CW'(1));
  assign sum_i = acc_i + ACC_W'(s2_pi);
  assign sum_q = acc_q + ACC_W'(s2_pq);

  // Window length holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) len_q <= CW'(1);
    else        len_q <= len_use;
  end

  // S1: capture accepted samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_adc   <= '0;
      s1_cos   <= '0;
      s1_sin   <= '0;
    end else begin
      s1_valid <= active & i_lo_valid;
      if (active && i_lo_valid) begin
        s1_adc <= i_adc;
        s1_cos <= i_lo_cos;
        s1_sin <= i_lo_sin;
      end
    end
  end

  // S2: full-precision signed products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_pi    <= '0;
      s2_pq    <= '0;
    end else begin
      s2_valid <= active & s1_valid;
      if (s1_valid) begin
        s2_pi <= PW'(s1_adc) * PW'(s1_cos);
        s2_pq <= PW'(s1_adc) * PW'(s1_sin);
      end
    end
  end

  // S3: accumulate; on the last product publish the sum and restart the
  // window in the same edge. Abort takes priority over completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_i   <= '0;
      acc_q   <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_i     <= '0;
      o_q     <= '0;
    end else begin
      o_valid <= 1'b0;
      if (!active) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else if (s2_valid) begin
        if (last) begin
          o_i     <= sum_i;
          o_q     <= sum_q;
          o_valid <= 1'b1;
          acc_i   <= '0;
          acc_q   <= '0;
          cnt     <= '0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + CW'(1);
        end
      end
    end
  end

  assign o_busy = (cnt != '0);

endmodule
